rf_req_ctrl: RTL and testbench

RF_REQ_CTRL -- requirements
Module: rf_req_ctrl

---
 rtl/rf_req_pkg.sv | 25 ++
 rtl/rf_ack_sync.sv | 29 ++
 rtl/rf_req_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rf_req_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_req_pkg.sv
// rf_req_pkg: shared definitions for the register-file request controller.
//   - cmd_op encodings (READ1 / READ2 / WRITE / illegal)
//   - controller state enum
//   - default ack wait limit used when RF_REQ_TIMEOUT_EN is defined
package rf_req_pkg;

    localparam logic [1:0] OP_READ1   = 2'b00;
    localparam logic [1:0] OP_READ2   = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        REL_A,
        REQ_B,
        REL_B,
        REQ_W,
        REL_W,
        RESP
    } state_e;

endpackage

// File: rtl/rf_ack_sync.sv
// rf_ack_sync: two-flop synchronizer for the responder acknowledge.
// Ports:
//   clk     - sampling clock
//   rst     - synchronous active-high clear of both flops
//   async_i - asynchronous input (rf_ack)
//   sync_o  - synchronized output, two cycles of latency
module rf_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/rf_req_ctrl.sv
// rf_req_ctrl: accepts READ1 / READ2 / WRITE commands and performs them on a
// register file through a four-phase enable/ack handshake with an
// asynchronous responder, then returns one response per command.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   cmd_valid/cmd_ready             - command handshake
//   cmd_op, cmd_raddr_a/b,
//   cmd_waddr, cmd_wdata            - command fields
//   rf_in_address_1/2,
//   rf_read_enable_1/2              - register-file read requests
//   rf_write_address_1/data_1/
//   enable_1                        - register-file write request
//   rf_out_data_1/2, rf_ack         - read data and asynchronous acknowledge
//   rsp_valid/rsp_ready,
//   rsp_data_a/b, rsp_err           - response handshake and payload
// Build option: RF_REQ_TIMEOUT_EN adds a per-state watchdog; after TIMEOUT
// cycles in any request/release state the enables drop and the command
// completes with rsp_err=1.
module rf_req_ctrl
    import rf_req_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [3:0]   cmd_raddr_a,
    input  logic [3:0]   cmd_raddr_b,
    input  logic [3:0]   cmd_waddr,
    input  logic [N-1:0] cmd_wdata,
    output logic [3:0]   rf_in_address_1,
    output logic [3:0]   rf_in_address_2,
    output logic         rf_read_enable_1,
    output logic         rf_read_enable_2,
    output logic [3:0]   rf_write_address_1,
    output logic [N-1:0] rf_write_data_1,
    output logic         rf_write_enable_1,
    input  logic [N-1:0] rf_out_data_1,
    input  logic [N-1:0] rf_out_data_2,
    input  logic         rf_ack,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data_a,
    output logic [N-1:0] rsp_data_b,
    output logic         rsp_err
);

    state_e       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [3:0]   raddr_a_q, raddr_a_d;
    logic [3:0]   raddr_b_q, raddr_b_d;
    logic [3:0]   waddr_q, waddr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] data_a_q, data_a_d;
    logic [N-1:0] data_b_q, data_b_d;
    logic         err_q, err_d;
    // Set once ack_s has been seen low in the current state; a request
    // phase only completes after this, so a stale ack cannot finish it.
    logic         seen_low_q, seen_low_d;
    logic         ack_s;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("rf_req_ctrl: TIMEOUT must be within 2..255");
    end

    rf_ack_sync u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rf_ack),
        .sync_o  (ack_s)
    );

`ifdef RF_REQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       in_phase;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        raddr_a_d  = raddr_a_q;
        raddr_b_d  = raddr_b_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        err_d      = err_q;
        seen_low_d = seen_low_q | ~ack_s;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    raddr_a_d = cmd_raddr_a;
                    raddr_b_d = cmd_raddr_b;
                    waddr_d   = cmd_waddr;
                    wdata_d   = cmd_wdata;
                    data_a_d  = '0;
                    data_b_d  = '0;
                    err_d     = 1'b0;
                    case (cmd_op)
                        OP_READ1, OP_READ2: state_d = REQ_A;
                        OP_WRITE:           state_d = REQ_W;
                        default: begin
                            state_d = RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            REQ_A: begin
                if (ack_s && seen_low_q) begin
                    data_a_d = rf_out_data_1;
                    state_d  = REL_A;
                end
            end
            REL_A: begin
                if (!ack_s) state_d = (op_q == OP_READ2) ? REQ_B : RESP;
            end
            REQ_B: begin
                if (ack_s && seen_low_q) begin
                    data_b_d = rf_out_data_2;
                    state_d  = REL_B;
                end
            end
            REL_B: if (!ack_s) state_d = RESP;
            REQ_W: if (ack_s && seen_low_q) state_d = REL_W;
            REL_W: if (!ack_s) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef RF_REQ_TIMEOUT_EN
        // Watchdog overrides any handshake progress made in the same cycle.
        in_phase = (state_q != IDLE) && (state_q != RESP);
        cnt_d    = '0;
        if (in_phase && (cnt_q == TMO_LAST)) begin
            state_d = RESP;
            err_d   = 1'b1;
        end else if (in_phase && (state_d == state_q)) begin
            cnt_d = cnt_q + 8'd1;
        end
`endif

        if (state_d != state_q) seen_low_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            raddr_a_q  <= '0;
            raddr_b_q  <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            err_q      <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            raddr_a_q  <= raddr_a_d;
            raddr_b_q  <= raddr_b_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            err_q      <= err_d;
            seen_low_q <= seen_low_d;
        end
    end

`ifdef RF_REQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign cmd_ready          = (state_q == IDLE) && !rst;
    assign rf_read_enable_1   = (state_q == REQ_A);
    assign rf_read_enable_2   = (state_q == REQ_B);
    assign rf_write_enable_1  = (state_q == REQ_W);
    assign rf_in_address_1    = raddr_a_q;
    assign rf_in_address_2    = raddr_b_q;
    assign rf_write_address_1 = waddr_q;
    assign rf_write_data_1    = wdata_q;
    assign rsp_valid          = (state_q == RESP);
    assign rsp_data_a         = data_a_q;
    assign rsp_data_b         = data_b_q;
    assign rsp_err            = err_q;

endmodule

// File: tb/tb_rf_req_ctrl.sv
// tb_rf_req_ctrl: directed + randomized bench for rf_req_ctrl with a
// behavioural register-file responder and a command-level reference model.
module tb_rf_req_ctrl;
    import rf_req_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_raddr_a, cmd_raddr_b, cmd_waddr;
    logic [31:0] cmd_wdata;
    logic [3:0]  rf_in_address_1, rf_in_address_2, rf_write_address_1;
    logic        rf_read_enable_1, rf_read_enable_2, rf_write_enable_1;
    logic [31:0] rf_write_data_1, rf_out_data_1, rf_out_data_2;
    logic        rf_ack;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data_a, rsp_data_b;

    rf_req_ctrl #(.N(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_raddr_a(cmd_raddr_a), .cmd_raddr_b(cmd_raddr_b),
        .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata),
        .rf_in_address_1(rf_in_address_1), .rf_in_address_2(rf_in_address_2),
        .rf_read_enable_1(rf_read_enable_1), .rf_read_enable_2(rf_read_enable_2),
        .rf_write_address_1(rf_write_address_1), .rf_write_data_1(rf_write_data_1),
        .rf_write_enable_1(rf_write_enable_1),
        .rf_out_data_1(rf_out_data_1), .rf_out_data_2(rf_out_data_2),
        .rf_ack(rf_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // ---------------- responder (the register file) ----------------
    logic [31:0] rf_mem [16];
    logic [31:0] preload [16];
    logic        mem_load = 1'b0;
    logic        ack_q = 1'b0;
    int unsigned rcnt = 0;
    int unsigned ack_dly = 0;
    logic        no_ack = 1'b0;
    logic        force_ack = 1'b0;

    assign rf_ack        = ack_q | force_ack;
    assign rf_out_data_1 = rf_mem[rf_in_address_1];
    assign rf_out_data_2 = rf_mem[rf_in_address_2];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= preload[i];
        end else if (!ack_q) begin
            if ((rf_read_enable_1 || rf_read_enable_2 || rf_write_enable_1) && !no_ack) begin
                if (rcnt >= ack_dly) begin
                    ack_q <= 1'b1;
                    rcnt  <= 0;
                    if (rf_write_enable_1) rf_mem[rf_write_address_1] <= rf_write_data_1;
                end else begin
                    rcnt <= rcnt + 1;
                end
            end else begin
                rcnt <= 0;
            end
        end else if (!(rf_read_enable_1 || rf_read_enable_2 || rf_write_enable_1)) begin
            ack_q <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    logic [3:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;
    int unsigned onehot_viol = 0, wr_viol = 0, ord_viol = 0, fall_viol = 0;
    int unsigned ack_low_run = 0, ack_high_run = 0;
    logic        prev_en2 = 1'b0, prev_any = 1'b0;

    always @(negedge clk) begin
        if ((32'(rf_read_enable_1) + 32'(rf_read_enable_2) + 32'(rf_write_enable_1)) > 1)
            onehot_viol <= onehot_viol + 1;
        if (rf_write_enable_1 && (rf_write_address_1 !== exp_wa || rf_write_data_1 !== exp_wd))
            wr_viol <= wr_viol + 1;
        // Port-2 read may only start once the synchronized ack has been low,
        // i.e. after at least three sampled cycles of raw ack low.
        if (rf_read_enable_2 && !prev_en2 && ack_low_run < 3)
            ord_viol <= ord_viol + 1;
`ifndef RF_REQ_TIMEOUT_EN
        if (!rst && prev_any && !(rf_read_enable_1 || rf_read_enable_2 || rf_write_enable_1)
            && ack_high_run < 3)
            fall_viol <= fall_viol + 1;
`endif
        if (rf_ack) begin ack_high_run <= ack_high_run + 1; ack_low_run <= 0; end
        else        begin ack_low_run  <= ack_low_run + 1;  ack_high_run <= 0; end
        prev_en2 <= rf_read_enable_2;
        prev_any <= rf_read_enable_1 || rf_read_enable_2 || rf_write_enable_1;
    end

    // ---------------- reference model + checking ----------------
    int unsigned checks = 0, failures = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] exp_a, exp_b;
    logic        exp_err;
    logic        pend_we = 1'b0;
    logic [3:0]  pend_wa;
    logic [31:0] pend_wd;
    int unsigned w_lat, w_en;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_en"},    {rf_read_enable_1, rf_read_enable_2, rf_write_enable_1}, 0);
        check({tag, "_addr"},  {rf_in_address_1, rf_in_address_2, rf_write_address_1}, 0);
        check({tag, "_wdata"}, rf_write_data_1, 0);
        check({tag, "_rsp"},   {rsp_valid, rsp_err}, 0);
        check({tag, "_data_a"}, rsp_data_a, 0);
        check({tag, "_data_b"}, rsp_data_b, 0);
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    // Computes the expected response from the command rules, then presents the
    // command and returns on the sample right after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] wa, input logic [31:0] wd);
        int unsigned n;
        exp_a = '0; exp_b = '0; exp_err = 1'b0; pend_we = 1'b0;
        case (op)
            OP_READ1: exp_a = ref_mem[ra];
            OP_READ2: begin exp_a = ref_mem[ra]; exp_b = ref_mem[rb]; end
            OP_WRITE: begin pend_we = 1'b1; pend_wa = wa; pend_wd = wd; end
            default:  exp_err = 1'b1;
        endcase
        exp_wa = wa; exp_wd = wd;
        cmd_op = op; cmd_raddr_a = ra; cmd_raddr_b = rb; cmd_waddr = wa; cmd_wdata = wd;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        check("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int unsigned stall);
        logic [65:0] snap;
        int unsigned sv;
        w_lat = 0; w_en = 0;
        while (!rsp_valid && w_lat < 400) begin
            if (rf_read_enable_1 || rf_read_enable_2 || rf_write_enable_1) w_en++;
            step();
            w_lat++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1);
        if (rsp_valid) begin
            check({tag, "_data_a"}, rsp_data_a, exp_a);
            check({tag, "_data_b"}, rsp_data_b, exp_b);
            check({tag, "_err"}, rsp_err, exp_err);
            check({tag, "_en_at_rsp"}, {rf_read_enable_1, rf_read_enable_2, rf_write_enable_1}, 0);
            snap = {rsp_valid, rsp_err, rsp_data_a, rsp_data_b};
            sv = 0;
            rsp_ready = 1'b0;
            for (int k = 0; k < int'(stall); k++) begin
                step();
                if ({rsp_valid, rsp_err, rsp_data_a, rsp_data_b} !== snap) sv++;
            end
            if (stall > 0) check({tag, "_stall_stable"}, sv, 0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check({tag, "_back_idle"}, {rsp_valid, cmd_ready}, 2'b01);
            if (pend_we && !exp_err) ref_mem[pend_wa] = pend_wd;
        end
        pend_we = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0]  rop;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_raddr_a = '0; cmd_raddr_b = '0; cmd_waddr = '0; cmd_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            preload[i] = v;
            ref_mem[i] = v;
        end
        preload[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;
        preload[1] = 32'h11;       ref_mem[1] = 32'h11;
        preload[2] = 32'h22;       ref_mem[2] = 32'h22;
        mem_load = 1'b1;
        repeat (3) step();
        mem_load = 1'b0;
        rst = 1'b0;
        step();
        check_reset_state("por");

        // READ1 of R3, ack three cycles after the enable
        ack_dly = 2;
        send_cmd(OP_READ1, 4'd3, 4'd0, 4'd0, 32'h0);
        wait_rsp("read1", 0);

        // READ2 of R1/R2
        ack_dly = 1;
        send_cmd(OP_READ2, 4'd1, 4'd2, 4'd0, 32'h0);
        wait_rsp("read2", 0);

        // WRITE then read back
        ack_dly = 0;
        send_cmd(OP_WRITE, 4'd0, 4'd0, 4'd5, 32'hA5A5A5A5);
        wait_rsp("write5", 0);
        send_cmd(OP_READ1, 4'd5, 4'd0, 4'd0, 32'h0);
        wait_rsp("readback5", 0);
        check("readback5_value", rsp_data_a, 32'hA5A5A5A5);

        // Illegal op: response on the cycle after acceptance, no enables
        send_cmd(OP_ILLEGAL, 4'd7, 4'd8, 4'd9, 32'h1234);
        wait_rsp("illegal", 0);
        check("illegal_lat", w_lat, 0);
        check("illegal_en_cycles", w_en, 0);

        // Stale ack: ack already high when REQ_A is entered
        no_ack = 1'b1; force_ack = 1'b1;
        repeat (4) step();
        send_cmd(OP_READ1, 4'd7, 4'd0, 4'd0, 32'h0);
        repeat (6) step();
        check("stale_en_held", {rf_read_enable_1, rsp_valid}, 2'b10);
        ack_dly = 1; no_ack = 1'b0; force_ack = 1'b0;
        wait_rsp("stale", 0);

        // Responder never acknowledges
        no_ack = 1'b1;
`ifdef RF_REQ_TIMEOUT_EN
        send_cmd(OP_READ1, 4'd4, 4'd0, 4'd0, 32'h0);
        exp_err = 1'b1; exp_a = '0; exp_b = '0;
        wait_rsp("timeout", 0);
        check("timeout_lat", w_lat, 15);
        check("timeout_en_cycles", w_en, 15);
`else
        send_cmd(OP_READ1, 4'd4, 4'd0, 4'd0, 32'h0);
        repeat (100) step();
        check("noack_en_held", {rf_read_enable_1, rsp_valid}, 2'b10);
        rst = 1'b1;
        step();
        check("noack_abort_en", {rf_read_enable_1, rf_read_enable_2, rf_write_enable_1}, 0);
        step();
        rst = 1'b0;
        step();
        check_reset_state("noack_rst");
        pend_we = 1'b0;
`endif
        no_ack = 1'b0;

        // Stalled response, then reset in the middle of a write
        ack_dly = 1;
        send_cmd(OP_WRITE, 4'd0, 4'd0, 4'd9, 32'h5A5A0F0F);
        wait_rsp("stall_write", 10);
        no_ack = 1'b1;
        send_cmd(OP_WRITE, 4'd0, 4'd0, 4'd9, 32'hFFFF0000);
        repeat (3) step();
        check("abort_we_held", rf_write_enable_1, 1);
        rst = 1'b1;
        step();
        check("abort_en", {rf_read_enable_1, rf_read_enable_2, rf_write_enable_1}, 0);
        step();
        rst = 1'b0;
        pend_we = 1'b0;
        no_ack = 1'b0;
        step();
        check_reset_state("abort");
        send_cmd(OP_READ1, 4'd9, 4'd0, 4'd0, 32'h0);
        wait_rsp("after_abort", 0);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            ack_dly = $urandom_range(0, 4);
            rop = 2'($urandom_range(0, 3));
            send_cmd(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), $urandom);
            wait_rsp("rand", $urandom_range(0, 3));
        end

        check("onehot_enables", onehot_viol, 0);
        check("write_stable", wr_viol, 0);
        check("port2_after_release", ord_viol, 0);
        check("enable_held_until_ack", fall_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
